// File: rtl/vga_timing_gen.sv
// XGA 1024x768@60 video timing generator on the PLL pixel clock.
// Define VGA_TEST_PATTERN_EN to drive 8 colour bars on rgb.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        locked,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        run;
    logic        vis;
    logic        h_in;
    logic        v_in;

    // Lock loss is handled exactly like reset so a frame never resumes mid-way.
    assign run  = locked & ~reset;
    assign vis  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign h_in = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign v_in = (v_cnt >= V_SS) && (v_cnt < V_SE);

    always_ff @(posedge clk_in) begin
        if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!run) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_in ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in ? SYNC_POL : ~SYNC_POL;
            active      <= vis;
            x           <= vis ? h_cnt : '0;
            y           <= vis ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] bar;

    always_comb begin
        bar = 8'h00;
        unique case (h_cnt[9:7])
            3'd0: bar = 8'hFF;
            3'd1: bar = 8'hFC;
            3'd2: bar = 8'h1F;
            3'd3: bar = 8'h1C;
            3'd4: bar = 8'hE3;
            3'd5: bar = 8'hE0;
            3'd6: bar = 8'h03;
            3'd7: bar = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        rgb <= (run && vis) ? bar : 8'h00;
    end
`else
    assign rgb = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size XGA line checks plus a shrunken-timing
// instance (SYNC_POL=1) for frame, vsync and lock-loss checks.
module tb_vga_timing_gen;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        reset, locked;
    logic        hsync, vsync, active, line_start, frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  rgb;

    logic        reset_s, locked_s;
    logic        hsync_s, vsync_s, active_s, line_start_s, frame_start_s;
    logic [10:0] x_s;
    logic [9:0]  y_s;
    logic [7:0]  rgb_s;

    int n_chk = 0;
    int n_pass = 0;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [7:0] RGB_X0    = 8'hFF;
    localparam logic [7:0] RGB_X128  = 8'hFC;
`else
    localparam logic [7:0] RGB_X0    = 8'h00;
    localparam logic [7:0] RGB_X128  = 8'h00;
`endif

    vga_timing_gen dut (
        .clk_in(clk_in), .reset(reset), .locked(locked),
        .hsync(hsync), .vsync(vsync), .active(active),
        .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start), .rgb(rgb)
    );

    // 24 x 13 total, 16 x 8 visible, sync asserted high.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk_in(clk_in), .reset(reset_s), .locked(locked_s),
        .hsync(hsync_s), .vsync(vsync_s), .active(active_s),
        .x(x_s), .y(y_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .rgb(rgb_s)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int act_n, hs_n, hs_first, ls_n, vs_lo, rgb_bad;
        logic [7:0] rgb0, rgb128, rgb1023, rgb_blank;
        logic [10:0] x1023, x1024;
        int fs_n, fs_second, vs_n, vs_first, hs_s_n, act_s_n, act_lines;
        int vs_edge_bad, rgb_s_bad;
        logic vs_prev;

        reset = 1'b1; locked = 1'b1;
        reset_s = 1'b1; locked_s = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 9) begin
                chk("rst_hsync", hsync, 1);
                chk("rst_vsync", vsync, 1);
                chk("rst_active", active, 0);
                chk("rst_x", x, 0);
                chk("rst_y", y, 0);
                chk("rst_ls", line_start, 0);
                chk("rst_fs", frame_start, 0);
                chk("rst_rgb", rgb, 0);
                chk("rst_hsync_s", hsync_s, 0);
                chk("rst_vsync_s", vsync_s, 0);
            end
        end

        reset = 1'b0;
        step();
        chk("first_active", active, 1);
        chk("first_fs", frame_start, 1);
        chk("first_ls", line_start, 1);
        chk("first_x", x, 0);
        chk("first_y", y, 0);

        act_n = 0; hs_n = 0; hs_first = -1; ls_n = 0; vs_lo = 0;
        rgb_bad = 0;
        rgb0 = 0; rgb128 = 0; rgb1023 = 0; rgb_blank = 0;
        x1023 = 0; x1024 = 0;
        for (int k = 0; k < 1344; k++) begin
            if (active) act_n++;
            if (!hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = k;
            end
            if (line_start) ls_n++;
            if (!vsync) vs_lo++;
            if (!active && rgb != 8'h00) rgb_bad++;
            if (k == 0) rgb0 = rgb;
            if (k == 128) rgb128 = rgb;
            if (k == 1023) begin rgb1023 = rgb; x1023 = x; end
            if (k == 1024) x1024 = x;
            if (k == 1100) rgb_blank = rgb;
            step();
        end
        chk("line_active", act_n, 1024);
        chk("hsync_width", hs_n, 136);
        chk("hsync_start", hs_first, 1048);
        chk("ls_per_line", ls_n, 1);
        chk("vsync_line0", vs_lo, 0);
        chk("x_last", x1023, 1023);
        chk("x_blank", x1024, 0);
        chk("rgb_x0", rgb0, RGB_X0);
        chk("rgb_x128", rgb128, RGB_X128);
        chk("rgb_x1023", rgb1023, 0);
        chk("rgb_blank", rgb_blank, 0);
        chk("rgb_blank_all", rgb_bad, 0);
        chk("ls_period", line_start, 1);
        chk("line1_y", y, 1);
        chk("line1_fs", frame_start, 0);

        reset_s = 1'b0;
        step();
        chk("s_first_fs", frame_start_s, 1);
        chk("s_first_act", active_s, 1);
        chk("s_first_hsync", hsync_s, 0);

        fs_n = 0; fs_second = -1; vs_n = 0; vs_first = -1;
        hs_s_n = 0; act_s_n = 0; act_lines = 0;
        vs_edge_bad = 0; rgb_s_bad = 0;
        vs_prev = vsync_s;
        for (int k = 0; k < 624; k++) begin
            if (frame_start_s) begin
                fs_n++;
                if (k > 0 && fs_second < 0) fs_second = k;
            end
            if (k < 312 && vsync_s) begin
                vs_n++;
                if (vs_first < 0) vs_first = k;
            end
            if (hsync_s) hs_s_n++;
            if (k < 312 && active_s) act_s_n++;
            if (k < 312 && line_start_s && active_s) act_lines++;
            if (vsync_s != vs_prev && !line_start_s) vs_edge_bad++;
            if (rgb_s != 8'h00 && !active_s) rgb_s_bad++;
            vs_prev = vsync_s;
            step();
        end
        chk("s_fs_count", fs_n, 2);
        chk("s_fs_period", fs_second, 312);
        chk("s_fs_wrap", frame_start_s, 1);
        chk("s_vsync_width", vs_n, 48);
        chk("s_vsync_start", vs_first, 216);
        chk("s_hsync_total", hs_s_n, 78);
        chk("s_active_px", act_s_n, 128);
        chk("s_active_lines", act_lines, 8);
        chk("s_vs_edge", vs_edge_bad, 0);
        chk("s_rgb_blank", rgb_s_bad, 0);

        for (int k = 0; k < 77; k++) step();
        chk("s_pre_x", x_s, 5);
        chk("s_pre_y", y_s, 3);
        locked_s = 1'b0;
        step();
        chk("lk_active", active_s, 0);
        chk("lk_x", x_s, 0);
        chk("lk_y", y_s, 0);
        chk("lk_hsync", hsync_s, 0);
        chk("lk_vsync", vsync_s, 0);
        chk("lk_ls", line_start_s, 0);
        step();
        step();
        chk("lk_hold", active_s, 0);
        locked_s = 1'b1;
        step();
        chk("relock_fs", frame_start_s, 1);
        chk("relock_ls", line_start_s, 1);
        chk("relock_x", x_s, 0);
        chk("relock_y", y_s, 0);
        step();
        chk("relock_x1", x_s, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
